// File: rtl/fc_pkg.sv
// Shared constants and types for the six-region four-color backtracking solver.
// The map is fixed: ADJ[a][b] is set when regions a and b share a border.
package fc_pkg;

    localparam int NUM_REGIONS = 6;
    localparam int COLOR_W     = 2;
    localparam int IDX_W       = 3;

    typedef logic [COLOR_W-1:0] color_t;
    typedef logic [IDX_W-1:0]   idx_t;

    localparam color_t COLOR_MAX = 2'd3;
    localparam idx_t   LAST_IDX  = 3'd5;

    // Rows listed region 5 first; row r holds a 1 in bit j for each neighbour j of r.
    localparam logic [NUM_REGIONS-1:0][NUM_REGIONS-1:0] ADJ = {
        6'b010100,  // 5: 2,4
        6'b101010,  // 4: 1,3,5
        6'b010111,  // 3: 0,1,2,4
        6'b101011,  // 2: 0,1,3,5
        6'b011101,  // 1: 0,2,3,4
        6'b001110   // 0: 1,2,3
    };

    typedef enum logic [1:0] {
        ST_START,
        ST_SOLVE,
        ST_DONE,
        ST_FAIL
    } fc_state_e;

endpackage

// File: rtl/fc_conflict_check.sv
// Combinational check: does region i share a color with any already-colored
// neighbour j < i?
module fc_conflict_check
    import fc_pkg::*;
(
    input  color_t [NUM_REGIONS-1:0] c_i,
    input  idx_t                     i_i,
    output logic                     conflict_o
);

    always_comb begin
        conflict_o = 1'b0;
        for (int j = 0; j < NUM_REGIONS; j++) begin
            if (idx_t'(j) < i_i && ADJ[i_i][j] && c_i[j] == c_i[i_i]) begin
                conflict_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/top.sv
// Four-color solver for a fixed six-region map: one DFS candidate per clock,
// single-cycle backtracking, restart from a synchronized push button.
module top
    import fc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  pb,
    output logic [11:0] led
);

    fc_state_e                state_q, state_d;
    idx_t                     idx_q, idx_d;
    color_t [NUM_REGIONS-1:0] col_q, col_d;

    logic pb_meta_q, pb_sync_q, pb_prev_q;
    logic restart;
    logic conflict;
    logic bt_found;
    idx_t bt_k;
    logic unused_pb;

    assign unused_pb = ^pb[4:1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pb_meta_q <= 1'b0;
            pb_sync_q <= 1'b0;
            pb_prev_q <= 1'b0;
        end else begin
            pb_meta_q <= pb[0];
            pb_sync_q <= pb_meta_q;
            pb_prev_q <= pb_sync_q;
        end
    end

    assign restart = pb_sync_q & ~pb_prev_q;

    fc_conflict_check u_conflict (
        .c_i        (col_q),
        .i_i        (idx_q),
        .conflict_o (conflict)
    );

    // Nearest lower region that still has an untried color; ascending scan, last hit wins.
    always_comb begin
        bt_found = 1'b0;
        bt_k     = '0;
        for (int k = 0; k < NUM_REGIONS; k++) begin
            if (idx_t'(k) < idx_q && col_q[k] != COLOR_MAX) begin
                bt_found = 1'b1;
                bt_k     = idx_t'(k);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        col_d   = col_q;
        case (state_q)
            ST_START: begin
                idx_d   = '0;
                col_d   = '0;
                state_d = ST_SOLVE;
            end
            ST_SOLVE: begin
                if (!conflict) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d                = idx_q + 3'd1;
                        col_d[idx_q + 3'd1]  = '0;
                    end
                end else if (col_q[idx_q] != COLOR_MAX) begin
                    col_d[idx_q] = col_q[idx_q] + 2'd1;
                end else if (bt_found) begin
                    for (int j = 0; j < NUM_REGIONS; j++) begin
                        if (idx_t'(j) > bt_k && idx_t'(j) <= idx_q) col_d[j] = '0;
                    end
                    col_d[bt_k] = col_q[bt_k] + 2'd1;
                    idx_d       = bt_k;
                end else begin
                    state_d = ST_FAIL;
                end
            end
            ST_DONE, ST_FAIL: ;
            default: state_d = ST_START;
        endcase
        if (restart) begin
            state_d = ST_START;
            idx_d   = '0;
            col_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_START;
            idx_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
        end
    end

    assign led = (state_q == ST_FAIL) ? 12'hFFF : col_q;

endmodule

// File: tb/tb_top.sv
// Bench for the four-color solver: directed table, restart/abort sequences and
// random restarts checked against a stack-based DFS model of the search.
module tb_top;

    localparam logic [11:0] FINAL_LED = 12'h4E4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  pb;
    logic [11:0] led;

    int n_tests = 0;
    int n_fail  = 0;
    int phase   = 0;
    int pend    = 0;

    logic [11:0] trace_led [$];
    int          trace_depth [$];
    logic [11:0] final_led;

    int edge_a [10] = '{0, 0, 0, 1, 1, 2, 1, 3, 2, 4};
    int edge_b [10] = '{1, 2, 3, 2, 3, 3, 4, 4, 5, 5};

    typedef struct {
        int          edge_n;
        logic [11:0] led_exp;
    } vec_t;
    vec_t vecs [14];

    top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pb    (pb),
        .led   (led)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic bit adjacent(int a, int b);
        for (int e = 0; e < 10; e++) begin
            if ((edge_a[e] == a && edge_b[e] == b) || (edge_a[e] == b && edge_b[e] == a)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // True when no bordering pair among regions below ndone shows equal colors.
    function automatic bit proper_prefix(logic [11:0] l, int ndone);
        for (int e = 0; e < 10; e++) begin
            if (edge_b[e] < ndone && l[2*edge_a[e] +: 2] == l[2*edge_b[e] +: 2]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // DFS over a stack of colors; records the led image of every candidate tested.
    task automatic build_model();
        int          stk [$];
        bit          ok;
        bit          fin;
        int          m;
        logic [11:0] l;
        fin = 1'b0;
        stk.push_back(0);
        for (int guard = 0; guard < 1000 && !fin; guard++) begin
            l = '0;
            foreach (stk[k]) l[2*k +: 2] = 2'(stk[k]);
            trace_led.push_back(l);
            trace_depth.push_back(stk.size());
            m  = stk.size() - 1;
            ok = 1'b1;
            for (int j = 0; j < m; j++) begin
                if (adjacent(j, m) && stk[j] == stk[m]) ok = 1'b0;
            end
            if (ok) begin
                if (stk.size() == 6) fin = 1'b1;
                else stk.push_back(0);
            end else begin
                while (stk.size() > 0 && stk[stk.size()-1] == 3) void'(stk.pop_back());
                if (stk.size() == 0) fin = 1'b1;
                else stk[stk.size()-1] = stk[stk.size()-1] + 1;
            end
        end
        final_led = '0;
        foreach (stk[k]) final_led[2*k +: 2] = 2'(stk[k]);
    endtask

    // phase counts edges since the solver entered START.
    function automatic logic [11:0] exp_led(int ph);
        if (ph == 0) return 12'h000;
        if (ph - 1 < trace_led.size()) return trace_led[ph-1];
        return final_led;
    endfunction

    task automatic step(input string nm);
        @(posedge clk);
        #1;
        if (phase < 100000) phase++;
        if (pend > 0) begin
            pend--;
            if (pend == 0) phase = 0;
        end
        check(nm, 32'(led), 32'(exp_led(phase)));
        pb[4:1] = 4'($urandom);
    endtask

    // Two synchronizer flops plus the edge flop put START on the third edge after a press.
    task automatic press();
        pb[0] = 1'b1;
        pend  = 3;
    endtask

    initial begin
        bit seen_zero;
        int lat;
        logic [11:0] first_bad;

        vecs[0]  = '{1,  12'h000};
        vecs[1]  = '{2,  12'h000};
        vecs[2]  = '{3,  12'h004};
        vecs[3]  = '{4,  12'h004};
        vecs[4]  = '{5,  12'h014};
        vecs[5]  = '{6,  12'h024};
        vecs[6]  = '{7,  12'h024};
        vecs[7]  = '{8,  12'h064};
        vecs[8]  = '{9,  12'h0A4};
        vecs[9]  = '{10, 12'h0E4};
        vecs[10] = '{11, 12'h0E4};
        vecs[11] = '{12, 12'h0E4};
        vecs[12] = '{13, 12'h4E4};
        vecs[13] = '{14, 12'h4E4};

        build_model();

        rst_n = 1'b0;
        pb    = '0;
        #1;
        check("reset_initial", 32'(led), 32'h000);
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            check("reset_hold", 32'(led), 32'h000);
        end

        rst_n = 1'b1;
        phase = 0;
        pend  = 0;
        for (int v = 0; v < 14; v++) begin
            step("solve_model");
            check($sformatf("solve_table_e%0d", vecs[v].edge_n), 32'(led), 32'(vecs[v].led_exp));
            if (phase >= 1 && phase <= trace_depth.size()) begin
                check("no_adjacent_equal", 32'(proper_prefix(led, trace_depth[phase-1] - 1)), 32'd1);
            end
        end

        first_bad = FINAL_LED;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            if (led !== FINAL_LED && first_bad == FINAL_LED) first_bad = led;
            pb[4:1] = 4'($urandom);
        end
        check("done_stable_10k", 32'(first_bad), 32'(FINAL_LED));

        press();
        seen_zero = 1'b0;
        lat       = 0;
        for (int c = 1; c <= 4; c++) begin
            step("restart_pulse");
            if (c == 3) pb[0] = 1'b0;
            if (!seen_zero && led == 12'h000) begin
                seen_zero = 1'b1;
                lat       = c;
            end
        end
        check("restart_latency_le4", 32'(seen_zero && lat <= 4), 32'd1);
        for (int c = 0; c < 13; c++) step("restart_resolve");
        check("restart_final", 32'(led), 32'(FINAL_LED));

        press();
        for (int c = 0; c < 60; c++) step("pb_held");
        check("pb_held_final", 32'(led), 32'(FINAL_LED));
        pb[0] = 1'b0;
        for (int c = 0; c < 5; c++) step("pb_released");

        press();
        for (int c = 0; c < 20 && !(pend == 0 && phase == 5); c++) begin
            step("pre_abort");
            pb[0] = 1'b0;
        end
        check("pre_abort_led", 32'(led), 32'h014);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_async", 32'(led), 32'h000);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("abort_hold", 32'(led), 32'h000);
        end
        rst_n = 1'b1;
        phase = 0;
        pend  = 0;
        for (int c = 0; c < 14; c++) step("abort_resolve");
        check("abort_final", 32'(led), 32'(FINAL_LED));

        for (int t = 0; t < 40; t++) begin
            int gap;
            gap = $urandom_range(0, 20);
            for (int c = 0; c < gap; c++) step("rand_gap");
            press();
            step("rand_press");
            pb[0] = 1'b0;
            step("rand_press");
            step("rand_press");
        end
        for (int c = 0; c < 16; c++) step("rand_tail");
        check("rand_final", 32'(led), 32'(FINAL_LED));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
